// File: rtl/noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_pkg: router port encoding and round-robin pick helper.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam int NUM_PORTS_DEF = 5;
  localparam int MAX_PORTS     = 16;
  localparam int MAX_IDX_W     = 4;

  // One-hot grant for the first set bit of req scanning ptr+1, ptr+2, ... mod n.
  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [MAX_PORTS-1:0] gnt;
    logic                 found;
    int unsigned          idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && req[idx[MAX_IDX_W-1:0]]) begin
        gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rr_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_rr_port_arb: grant/pointer state for one output port.            |
// | NOC_ARB_PKT_LOCK_EN selects packet (wormhole) mode. Rev 1.0          |
// +----------------------------------------------------------------------+
module noc_rr_port_arb
  import noc_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter bit ALLOW_UTURN = 1'b0,
  parameter int PORT_IDX    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] tail_i,
  input  logic                 ready_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] elig;
  logic [PTR_W-1:0]     holder;
  logic                 holder_req;
  logic                 xfer;
  logic                 release_gnt;

  always_comb begin
    elig = req_i;
    if (!ALLOW_UTURN) elig[PORT_IDX] = 1'b0;
  end

  always_comb begin
    holder = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q[i]) holder = PTR_W'(i);
    end
  end

  assign holder_req = |(gnt_q & req_i);
  assign xfer       = holder_req & ready_i;

`ifdef NOC_ARB_PKT_LOCK_EN
  assign release_gnt = xfer & |(gnt_q & tail_i);
`else
  logic unused_tail;
  assign unused_tail = ^tail_i;
  assign release_gnt = xfer;
`endif

  // A releasing holder becomes the pointer, so it is searched last.
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (gnt_q == '0) begin
      gnt_d = NUM_PORTS'(rr_pick(MAX_PORTS'(elig), 32'(ptr_q), NUM_PORTS));
    end else if (!holder_req) begin
      gnt_d = '0;
    end else if (release_gnt) begin
      ptr_d = holder;
      gnt_d = NUM_PORTS'(rr_pick(MAX_PORTS'(elig), 32'(holder), NUM_PORTS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= PTR_W'(PORT_IDX);
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_rr_arbiter: per-output round-robin switch arbiter for the router.|
// | NOC_ARB_PKT_LOCK_EN selects packet (wormhole) mode. Rev 1.0          |
// +----------------------------------------------------------------------+
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter bit ALLOW_UTURN = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0]           tail_i,
  input  logic [NUM_PORTS-1:0]           ready_i,
  output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
  output logic [NUM_PORTS-1:0]           busy_o
);

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_port
    noc_rr_port_arb #(
      .NUM_PORTS   (NUM_PORTS),
      .ALLOW_UTURN (ALLOW_UTURN),
      .PORT_IDX    (o)
    ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i[o*NUM_PORTS +: NUM_PORTS]),
      .tail_i  (tail_i),
      .ready_i (ready_i[o]),
      .gnt_o   (grant_o[o*NUM_PORTS +: NUM_PORTS])
    );
    assign busy_o[o] = |grant_o[o*NUM_PORTS +: NUM_PORTS];
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_noc_rr_arbiter: scoreboard bench for noc_rr_arbiter.              |
// | Honours NOC_ARB_PKT_LOCK_EN. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module tb_noc_rr_arbiter;

  localparam int N = 5;
  localparam int W = N * N;

`ifdef NOC_ARB_PKT_LOCK_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] req;
  logic [N-1:0] tail;
  logic [N-1:0] ready;
  logic [W-1:0] grant, grant_u;
  logic [N-1:0] busy, busy_u;

  int n_chk  = 0;
  int n_pass = 0;
  int m_h [N];
  int m_p [N];
  logic [W+N-1:0] exp_q [$];

  int rr_exp  [6] = '{3, 0, 1, 3, 0, 1};
  int lk_rdy  [7] = '{1, 1, 1, 0, 0, 1, 1};
  int lk_pkt  [7] = '{1, 1, 1, 1, 1, 1, 3};
  int lk_flit [7] = '{1, 3, 1, 1, 1, 3, 1};

  always #5 clk = ~clk;

  noc_rr_arbiter #(.NUM_PORTS(N), .ALLOW_UTURN(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .tail_i  (tail),
    .ready_i (ready),
    .grant_o (grant),
    .busy_o  (busy)
  );

  noc_rr_arbiter #(.NUM_PORTS(N), .ALLOW_UTURN(1'b1)) dut_u (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .tail_i  (tail),
    .ready_i (ready),
    .grant_o (grant_u),
    .busy_o  (busy_u)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Winner for output o scanning inputs after p; input o is never eligible.
  function automatic int search(int o, int p);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (req[o*N+i] && i != o) return i;
    end
    return -1;
  endfunction

  function automatic int gidx(logic [W-1:0] g, int o);
    for (int i = 0; i < N; i++) begin
      if (g[o*N+i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int nh [N];
    int np [N];
    logic [W+N-1:0] e;
    for (int o = 0; o < N; o++) begin
      nh[o] = m_h[o];
      np[o] = m_p[o];
      if (rst) begin
        nh[o] = -1;
        np[o] = o;
      end else if (m_h[o] < 0) begin
        nh[o] = search(o, m_p[o]);
      end else if (!req[o*N+m_h[o]]) begin
        nh[o] = -1;
      end else if (ready[o] && (!PKT || tail[m_h[o]])) begin
        np[o] = m_h[o];
        nh[o] = search(o, m_h[o]);
      end
    end
    e = '0;
    for (int o = 0; o < N; o++) begin
      m_h[o] = nh[o];
      m_p[o] = np[o];
      if (nh[o] >= 0) begin
        e[o*N+nh[o]] = 1'b1;
        e[W+o]       = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    logic [W+N-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_grant", 32'(grant), 32'(e[W-1:0]));
    check("sb_busy", 32'(busy), 32'(e[W+N-1:W]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int g_before;
    bit xfer1;
    for (int o = 0; o < N; o++) begin
      m_h[o] = -1;
      m_p[o] = o;
    end
    rst   = 1'b1;
    req   = '1;
    tail  = '1;
    ready = '1;

    repeat (2) begin
      cycle();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_grant", 32'(grant), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    cycle();
    req = '0;
    cycle();

    // single request: input 0 -> output 2
    do_reset();
    ready  = '1;
    tail   = 5'b00001;
    req[10] = 1'b1;
    cycle();
    check("single_b10", 32'(grant[10]), 32'd1);
    req = '0;
    cycle();

    // round robin: inputs 0,1,3 -> output 2
    do_reset();
    tail = '1;
    req[10] = 1'b1;
    req[11] = 1'b1;
    req[13] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("rr%0d", i), 32'(gidx(grant, 2)), 32'(rr_exp[i]));
    end
    req = '0;
    cycle();

    // 4-flit packet from input 1 vs single flits from input 3, output 0
    do_reset();
    tail    = '0;
    tail[3] = 1'b1;
    req[1]  = 1'b1;
    req[3]  = 1'b1;
    sent    = 0;
    for (int c = 0; c < 7; c++) begin
      ready[0] = (lk_rdy[c] != 0);
      tail[1]  = (sent == 3);
      req[1]   = (sent < 4);
      g_before = gidx(grant, 0);
      xfer1    = (g_before == 1) && ready[0] && req[1];
      cycle();
      if (xfer1) sent++;
      check($sformatf("lock%0d", c), 32'(gidx(grant, 0)),
            32'(PKT ? lk_pkt[c] : lk_flit[c]));
    end
    req   = '0;
    tail  = '0;
    ready = '1;
    cycle();

    // U-turn: input 2 -> output 2
    do_reset();
    req[12] = 1'b1;
    cycle();
    check("uturn_off", 32'(grant[12]), 32'd0);
    check("uturn_off_busy", 32'(busy[2]), 32'd0);
    check("uturn_on", 32'(grant_u[12]), 32'd1);
    req = '0;
    cycle();

    // reset in the middle of a multi-flit packet on output 0
    do_reset();
    ready  = '1;
    tail   = '0;
    req[1] = 1'b1;
    req[2] = 1'b1;
    req[4] = 1'b1;
    cycle();
    check("mid_first", 32'(gidx(grant, 0)), 32'd1);
    cycle();
    check("mid_second", 32'(gidx(grant, 0)), PKT ? 32'd1 : 32'd2);
    rst = 1'b1;
    cycle();
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cycle();
    check("mid_ptr_restart", 32'(gidx(grant, 0)), 32'd1);
    req = '0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
